fft_sample_loader: RTL and testbench

//  Sits between the UART frame controller and the radix-2 FFT core. Captures the

---
 rtl/fft_sample_loader.sv | 156 +++++++++++++++
 tb/tb_fft_sample_loader.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_sample_loader.sv
// Frame buffer between the UART frame controller and the radix-2 FFT core.
// Stores samples at bit-reversed addresses, starts the core and serves its reads.
module fft_sample_loader #(
    parameter int DATA_W  = 16,
    parameter int MAX_PTS = 32,
    parameter int ADDR_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        fft_select_i,
    input  logic              rx_start_i,
    input  logic              sample_valid_i,
    input  logic [DATA_W-1:0] sample_r_i,
    input  logic [DATA_W-1:0] sample_i_i,
    input  logic              rx_done_i,
    input  logic [ADDR_W-1:0] fft_rd_addr_i,
    output logic [DATA_W-1:0] fft_rd_data_r_o,
    output logic [DATA_W-1:0] fft_rd_data_i_o,
    input  logic              fft_done_i,
    output logic              fft_start_o,
    output logic [5:0]        fft_points_o,
    output logic [5:0]        sample_cnt_o,
    output logic              busy_o,
    output logic              err_o
);

    typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, READY = 2'd2, RUN = 2'd3} state_t;

    state_t            state;
    logic [1:0]        size_sel;
    logic [DATA_W-1:0] mem_r [0:MAX_PTS-1];
    logic [DATA_W-1:0] mem_i [0:MAX_PTS-1];
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic              count_full;

    // Only the low log2(N) bits of the index are mirrored; upper bits stay zero.
    function automatic logic [ADDR_W-1:0] bit_rev(input logic [ADDR_W-1:0] idx,
                                                  input logic [1:0] sel);
        case (sel)
            2'd0:    bit_rev = {2'b00, idx[0], idx[1], idx[2]};
            2'd1:    bit_rev = {1'b0, idx[0], idx[1], idx[2], idx[3]};
            2'd2:    bit_rev = {idx[0], idx[1], idx[2], idx[3], idx[4]};
            default: bit_rev = 5'd0;
        endcase
    endfunction

    function automatic logic [5:0] points_of(input logic [1:0] sel);
        case (sel)
            2'd0:    points_of = 6'd8;
            2'd1:    points_of = 6'd16;
            2'd2:    points_of = 6'd32;
            default: points_of = 6'd0;
        endcase
    endfunction

    assign count_full = (sample_cnt_o == fft_points_o);
    assign busy_o     = (state == READY) || (state == RUN);

    // Buffer write strobe and bit-reversed target address
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = bit_rev(sample_cnt_o[ADDR_W-1:0], size_sel);
        if (state == FILL && sample_valid_i && !rx_start_i && !count_full) begin
            wr_en = 1'b1;
        end else begin
            wr_en = 1'b0;
        end
    end

    // Frame state machine with registered status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            size_sel     <= 2'd0;
            fft_points_o <= 6'd0;
            sample_cnt_o <= 6'd0;
            err_o        <= 1'b0;
            fft_start_o  <= 1'b0;
        end else begin
            fft_start_o <= 1'b0;
            case (state)
                IDLE, FILL: begin
                    if (rx_start_i) begin
                        if (fft_select_i == 2'd3) begin
                            err_o        <= 1'b1;
                            fft_points_o <= 6'd0;
                            state        <= IDLE;
                        end else begin
                            size_sel     <= fft_select_i;
                            fft_points_o <= points_of(fft_select_i);
                            sample_cnt_o <= 6'd0;
                            err_o        <= 1'b0;
                            state        <= FILL;
                        end
                    end else if (state == FILL) begin
                        if (sample_valid_i) begin
                            if (count_full) begin
                                err_o <= 1'b1;
                            end else begin
                                sample_cnt_o <= sample_cnt_o + 6'd1;
                            end
                        end
                        // A sample arriving with the stop byte counts towards completion
                        if (rx_done_i) begin
                            if (count_full || (sample_valid_i && (sample_cnt_o + 6'd1 == fft_points_o))) begin
                                state <= READY;
                            end else begin
                                err_o        <= 1'b1;
                                fft_points_o <= 6'd0;
                                state        <= IDLE;
                            end
                        end
                    end
                end
                READY: begin
                    fft_start_o <= 1'b1;
                    state       <= RUN;
                    if (sample_valid_i || rx_start_i) begin
                        err_o <= 1'b1;
                    end
                end
                RUN: begin
                    if (sample_valid_i || rx_start_i) begin
                        err_o <= 1'b1;
                    end
                    if (fft_done_i) begin
                        fft_points_o <= 6'd0;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Sample buffer; contents are intentionally not reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= sample_r_i;
            mem_i[wr_addr] <= sample_i_i;
        end
    end

    // Registered read port, old data on a same-cycle write
    always_ff @(posedge clk) begin
        if (rst) begin
            fft_rd_data_r_o <= {DATA_W{1'b0}};
            fft_rd_data_i_o <= {DATA_W{1'b0}};
        end else begin
            fft_rd_data_r_o <= mem_r[fft_rd_addr_i];
            fft_rd_data_i_o <= mem_i[fft_rd_addr_i];
        end
    end

endmodule

// File: tb/tb_fft_sample_loader.sv
// Directed bench for fft_sample_loader: frames of each size, length errors,
// illegal size, buffer lock in RUN and reset mid-run.
module tb_fft_sample_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  fft_select_i = 2'd0;
    logic        rx_start_i = 1'b0;
    logic        sample_valid_i = 1'b0;
    logic [15:0] sample_r_i = 16'd0;
    logic [15:0] sample_i_i = 16'd0;
    logic        rx_done_i = 1'b0;
    logic [4:0]  fft_rd_addr_i = 5'd0;
    logic [15:0] fft_rd_data_r_o;
    logic [15:0] fft_rd_data_i_o;
    logic        fft_done_i = 1'b0;
    logic        fft_start_o;
    logic [5:0]  fft_points_o;
    logic [5:0]  sample_cnt_o;
    logic        busy_o;
    logic        err_o;

    int chk_cnt = 0;
    int pass_cnt = 0;
    int start_pulses = 0;

    fft_sample_loader dut (
        .clk(clk), .rst(rst), .fft_select_i(fft_select_i), .rx_start_i(rx_start_i),
        .sample_valid_i(sample_valid_i), .sample_r_i(sample_r_i), .sample_i_i(sample_i_i),
        .rx_done_i(rx_done_i), .fft_rd_addr_i(fft_rd_addr_i),
        .fft_rd_data_r_o(fft_rd_data_r_o), .fft_rd_data_i_o(fft_rd_data_i_o),
        .fft_done_i(fft_done_i), .fft_start_o(fft_start_o), .fft_points_o(fft_points_o),
        .sample_cnt_o(sample_cnt_o), .busy_o(busy_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (fft_start_o) start_pulses <= start_pulses + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame(input logic [1:0] sel);
        fft_select_i = sel;
        rx_start_i   = 1'b1;
        tick();
        rx_start_i   = 1'b0;
    endtask

    task automatic send_sample(input logic [15:0] r, input logic [15:0] i, input logic last);
        sample_r_i     = r;
        sample_i_i     = i;
        sample_valid_i = 1'b1;
        rx_done_i      = last;
        tick();
        sample_valid_i = 1'b0;
        rx_done_i      = 1'b0;
    endtask

    task automatic close_frame();
        rx_done_i = 1'b1;
        tick();
        rx_done_i = 1'b0;
    endtask

    task automatic finish_fft();
        fft_done_i = 1'b1;
        tick();
        fft_done_i = 1'b0;
    endtask

    task automatic read_addr(input logic [4:0] a, output logic [15:0] r, output logic [15:0] i);
        fft_rd_addr_i = a;
        tick();
        r = fft_rd_data_r_o;
        i = fft_rd_data_i_o;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        chk_cnt++;
        if ({fft_start_o, fft_points_o, sample_cnt_o, busy_o, err_o, fft_rd_data_r_o, fft_rd_data_i_o} !== 47'd0)
            $display("FAIL reset_outputs: got %h required 0",
                     {fft_start_o, fft_points_o, sample_cnt_o, busy_o, err_o, fft_rd_data_r_o, fft_rd_data_i_o});
        else pass_cnt++;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_fft8();
        logic [15:0] r, i, er, ei;
        int base;
        logic [15:0] rev8 [8] = '{16'd0, 16'd4, 16'd2, 16'd6, 16'd1, 16'd5, 16'd3, 16'd7};
        start_frame(2'd0);
        for (int k = 0; k < 8; k++) send_sample(16'(k), 16'd0 - 16'(k), 1'b0);
        base = start_pulses;
        close_frame();
        chk_cnt++;
        if (busy_o !== 1'b1) $display("FAIL fft8_busy: got %0d required 1", busy_o); else pass_cnt++;
        tick();
        tick();
        tick();
        chk_cnt++;
        if (start_pulses - base !== 1) $display("FAIL fft8_start_pulses: got %0d required 1", start_pulses - base);
        else pass_cnt++;
        chk_cnt++;
        if (fft_points_o !== 6'd8) $display("FAIL fft8_points: got %0d required 8", fft_points_o); else pass_cnt++;
        for (int a = 0; a < 8; a++) begin
            read_addr(5'(a), r, i);
            er = rev8[a];
            ei = 16'd0 - er;
            chk_cnt++;
            if (r !== er) $display("FAIL fft8_rd_r[%0d]: got %h required %h", a, r, er); else pass_cnt++;
            chk_cnt++;
            if (i !== ei) $display("FAIL fft8_rd_i[%0d]: got %h required %h", a, i, ei); else pass_cnt++;
        end
        finish_fft();
        chk_cnt++;
        if ({busy_o, fft_points_o} !== 7'd0) $display("FAIL fft8_idle_after_done: got %h required 0", {busy_o, fft_points_o});
        else pass_cnt++;
    endtask

    task automatic test_fft32();
        logic [15:0] r, i;
        int base;
        start_frame(2'd2);
        for (int k = 0; k < 32; k++) send_sample(16'(k), 16'(k + 100), 1'b0);
        base = start_pulses;
        close_frame();
        tick();
        tick();
        chk_cnt++;
        if (start_pulses - base !== 1) $display("FAIL fft32_start_pulses: got %0d required 1", start_pulses - base);
        else pass_cnt++;
        chk_cnt++;
        if (sample_cnt_o !== 6'd32) $display("FAIL fft32_cnt: got %0d required 32", sample_cnt_o); else pass_cnt++;
        chk_cnt++;
        if (err_o !== 1'b0) $display("FAIL fft32_err: got %0d required 0", err_o); else pass_cnt++;
        read_addr(5'd1, r, i);
        chk_cnt++;
        if (r !== 16'd16 || i !== 16'd116) $display("FAIL fft32_addr1: got %0d/%0d required 16/116", r, i); else pass_cnt++;
        read_addr(5'd31, r, i);
        chk_cnt++;
        if (r !== 16'd31) $display("FAIL fft32_addr31: got %0d required 31", r); else pass_cnt++;
        read_addr(5'd2, r, i);
        chk_cnt++;
        if (r !== 16'd8) $display("FAIL fft32_addr2: got %0d required 8", r); else pass_cnt++;
        finish_fft();
    endtask

    task automatic test_underrun();
        int base;
        base = start_pulses;
        start_frame(2'd1);
        for (int k = 0; k < 10; k++) send_sample(16'(k), 16'd0, 1'b0);
        close_frame();
        tick();
        tick();
        tick();
        chk_cnt++;
        if (err_o !== 1'b1) $display("FAIL underrun_err: got %0d required 1", err_o); else pass_cnt++;
        chk_cnt++;
        if (busy_o !== 1'b0) $display("FAIL underrun_busy: got %0d required 0", busy_o); else pass_cnt++;
        chk_cnt++;
        if (start_pulses - base !== 0) $display("FAIL underrun_start: got %0d required 0", start_pulses - base); else pass_cnt++;
        chk_cnt++;
        if (fft_points_o !== 6'd0) $display("FAIL underrun_points: got %0d required 0", fft_points_o); else pass_cnt++;
    endtask

    task automatic test_overflow();
        logic [15:0] r, i;
        int base;
        logic [15:0] rev8 [8] = '{16'd1, 16'd5, 16'd3, 16'd7, 16'd2, 16'd6, 16'd4, 16'd8};
        start_frame(2'd0);
        chk_cnt++;
        if (err_o !== 1'b0) $display("FAIL overflow_err_cleared: got %0d required 0", err_o); else pass_cnt++;
        for (int k = 0; k < 9; k++) send_sample(16'(k + 1), 16'h00aa, 1'b0);
        chk_cnt++;
        if (err_o !== 1'b1) $display("FAIL overflow_err: got %0d required 1", err_o); else pass_cnt++;
        chk_cnt++;
        if (sample_cnt_o !== 6'd8) $display("FAIL overflow_cnt: got %0d required 8", sample_cnt_o); else pass_cnt++;
        base = start_pulses;
        close_frame();
        tick();
        tick();
        chk_cnt++;
        if (start_pulses - base !== 1) $display("FAIL overflow_start: got %0d required 1", start_pulses - base); else pass_cnt++;
        for (int a = 0; a < 8; a++) begin
            read_addr(5'(a), r, i);
            chk_cnt++;
            if (r !== rev8[a]) $display("FAIL overflow_rd[%0d]: got %0d required %0d", a, r, rev8[a]); else pass_cnt++;
        end
        finish_fft();
    endtask

    task automatic test_illegal_size();
        start_frame(2'd3);
        chk_cnt++;
        if (err_o !== 1'b1) $display("FAIL illegal_err: got %0d required 1", err_o); else pass_cnt++;
        chk_cnt++;
        if ({busy_o, fft_points_o} !== 7'd0) $display("FAIL illegal_points: got %h required 0", {busy_o, fft_points_o}); else pass_cnt++;
        start_frame(2'd0);
        chk_cnt++;
        if (err_o !== 1'b0) $display("FAIL illegal_err_clear: got %0d required 0", err_o); else pass_cnt++;
        chk_cnt++;
        if (fft_points_o !== 6'd8) $display("FAIL illegal_then_points: got %0d required 8", fft_points_o); else pass_cnt++;
    endtask

    task automatic test_reset_in_run();
        logic [15:0] r, i;
        int base;
        start_frame(2'd0);
        for (int k = 0; k < 8; k++) send_sample(16'(k), 16'd0, 1'b0);
        close_frame();
        tick();
        tick();
        send_sample(16'hdead, 16'hbeef, 1'b0);
        chk_cnt++;
        if (err_o !== 1'b1 || busy_o !== 1'b1) $display("FAIL run_lock: got err=%0d busy=%0d required 1/1", err_o, busy_o);
        else pass_cnt++;
        read_addr(5'd0, r, i);
        chk_cnt++;
        if (r !== 16'd0) $display("FAIL run_lock_data: got %h required 0", r); else pass_cnt++;
        rst = 1'b1;
        tick();
        chk_cnt++;
        if ({fft_start_o, fft_points_o, sample_cnt_o, busy_o, err_o, fft_rd_data_r_o, fft_rd_data_i_o} !== 47'd0)
            $display("FAIL run_reset_outputs: got %h required 0",
                     {fft_start_o, fft_points_o, sample_cnt_o, busy_o, err_o, fft_rd_data_r_o, fft_rd_data_i_o});
        else pass_cnt++;
        rst = 1'b0;
        tick();
        base = start_pulses;
        start_frame(2'd0);
        for (int k = 0; k < 7; k++) send_sample(16'(k + 10), 16'd0, 1'b0);
        send_sample(16'd17, 16'd0, 1'b1);
        tick();
        tick();
        chk_cnt++;
        if (start_pulses - base !== 1) $display("FAIL post_reset_start: got %0d required 1", start_pulses - base); else pass_cnt++;
        read_addr(5'd4, r, i);
        chk_cnt++;
        if (r !== 16'd11) $display("FAIL post_reset_addr4: got %0d required 11", r); else pass_cnt++;
        read_addr(5'd7, r, i);
        chk_cnt++;
        if (r !== 16'd17) $display("FAIL post_reset_addr7: got %0d required 17", r); else pass_cnt++;
        chk_cnt++;
        if (err_o !== 1'b0) $display("FAIL post_reset_err: got %0d required 0", err_o); else pass_cnt++;
        finish_fft();
    endtask

    initial begin
        test_reset();
        test_fft8();
        test_fft32();
        test_underrun();
        test_overflow();
        test_illegal_size();
        test_reset_in_run();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
